pwm_deadtime: RTL
=================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 The block SHALL have parameter DT_W, default 8, giving the width of the dead-time count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port en, input, 1 bit: output-stage enable, level.
REQ-005 The block SHALL have port pwm_in, input, 1 bit: raw PWM from the PWM generator, synchronous to clk.
REQ-006 The block SHALL have port dead_time, input, DT_W bits: gap length in clk cycles during which both outputs are low.
REQ-007 The block SHALL have port fault, input, 1 bit: synchronous fault request, level.
REQ-008 The block SHALL have port fault_clr, input, 1 bit: one-cycle fault-clear pulse.
REQ-009 The block SHALL have port pwm_hi, output, 1 bit: high-side drive, registered.
REQ-010 The block SHALL have port pwm_lo, output, 1 bit: low-side drive, registered.
REQ-011 The block SHALL have port dt_active, output, 1 bit: high while in a dead-time state.
REQ-012 The block SHALL have port fault_latched, output, 1 bit: sticky fault flag.

Function
REQ-013 The FSM SHALL have the states IDLE, DT_RISE, HI_ON, DT_FALL, LO_ON and FAULT; all outputs SHALL be decoded from the registered state.
REQ-014 Output decode SHALL be: pwm_hi=1 only in HI_ON; pwm_lo=1 only in LO_ON; dt_active=1 in DT_RISE and DT_FALL; otherwise 0.
REQ-015 pwm_hi and pwm_lo SHALL never both be 1 in any cycle.
REQ-016 From IDLE with en=1, the FSM SHALL enter DT_RISE if pwm_in=1, else DT_FALL.
REQ-017 In LO_ON, sampling pwm_in=1 SHALL move the FSM to DT_RISE, or directly to HI_ON if dead_time=0.
REQ-018 In HI_ON, sampling pwm_in=0 SHALL move the FSM to DT_FALL, or directly to LO_ON if dead_time=0.
REQ-019 On entry to a DT state, the counter SHALL load dead_time-1; in a DT state the counter SHALL decrement each cycle; when the counter is 0 the FSM SHALL proceed to the target ON state (DT_RISE->HI_ON, DT_FALL->LO_ON).
REQ-020 Both outputs SHALL therefore be low for exactly dead_time cycles between any hi/lo change; latency from the pwm_in sample to the falling output SHALL be one edge.
REQ-021 Entry from IDLE with dead_time=0 SHALL still pass through one DT cycle.
REQ-022 Reversal of pwm_in during a DT state SHALL switch to the opposite DT state and reload the counter; a pulse shorter than dead_time is swallowed.
REQ-023 dead_time SHALL be sampled only on counter load; a change mid-gap SHALL not affect the current gap.
REQ-024 en=0 sampled in any non-FAULT state SHALL move the FSM to IDLE on that edge.
REQ-025 fault=1 sampled in any state SHALL move the FSM to FAULT and set fault_latched, with priority over en and pwm_in.
REQ-026 The FSM SHALL leave FAULT only when fault_clr=1 and fault=0 on the same edge; it then goes to IDLE and clears fault_latched.
REQ-027 fault_clr with fault=1 on the same edge SHALL be ignored (fault wins).
REQ-028 fault_clr outside FAULT SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state IDLE, counter 0, pwm_hi=0, pwm_lo=0, dt_active=0 and fault_latched=0.
REQ-030 Reset mid-gap or mid-fault SHALL discard all progress.
REQ-031 After rst_n rises, the first active edge SHALL follow REQ-016.

Structure
REQ-032 State encodings (3-bit) and DT_W default SHALL live in the shared PWM definitions package, reused by the top and the bench.
REQ-033 The down-counter (load, decrement, zero flag) SHALL be one sub-module, dt_counter; the FSM and output decode SHALL remain in pwm_deadtime.

Verification
REQ-034 Bench scenario: dead_time=3, pwm_in period 16 with 8 cycles high -> exactly 3 cycles both-low at each edge, pwm_hi high 5, pwm_lo high 5 per period.
REQ-035 Bench scenario: dead_time=0, same pwm_in -> pwm_hi high 8, pwm_lo high 8, both never high together, one-edge latency.
REQ-036 Bench scenario: dead_time=5, 2-cycle pwm_in high pulse -> pwm_hi stays 0, dt_active high through the gap, then pwm_lo returns.
REQ-037 Bench scenario: fault asserted in HI_ON -> both outputs 0 next edge and fault_latched=1; fault_clr while fault=1 ignored; fault_clr after fault=0 -> IDLE, then DT gap before any ON state.
REQ-038 Bench scenario: en=0 mid DT_FALL -> IDLE next edge, all outputs 0; rst_n pulsed low mid HI_ON -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/pwm_deadtime_pkg.sv
// Purpose: shared state encodings and defaults for the dead-time PWM output stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pwm_deadtime_pkg;

    // Default width of the dead-time count
    localparam int DT_W_DEF = 8;

    // 3-bit FSM state encoding shared by the RTL and the bench
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DT_RISE = 3'd1,
        HI_ON   = 3'd2,
        DT_FALL = 3'd3,
        LO_ON   = 3'd4,
        FAULT   = 3'd5
    } state_t;

    // True for the two gap states in which both drives are held low
    function automatic logic is_dt(input state_t s);
        return (s == DT_RISE) || (s == DT_FALL);
    endfunction

endpackage

// File: rtl/pwm_deadtime_dt.sv
// Purpose: dead-time down-counter with load, decrement and zero flag.
// Latency: load/decrement take effect on the next clk edge; o_zero is decoded from the count register.
// Backpressure: none; load has priority over decrement.
//
// Ports:
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   i_load     : load (i_len - 1), saturating at 0 so a zero gap still spends one cycle
//   i_len      : gap length in cycles
//   i_dec      : decrement by one (held at 0 once reached)
//   o_zero     : count register equals 0
module dt_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_len,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_len == '0) ? '0 : i_len - 1'b1;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Purpose: complementary high/low gate drive from a raw PWM with programmable dead time and sticky fault.
// Latency: one clk edge from the pwm_in sample to the falling drive; outputs are registers.
// Backpressure: none; fault overrides enable, enable overrides pwm_in.
//
// Ports:
//   clk, rst_n    : clock, async active-low reset (state IDLE, all outputs 0)
//   en            : output-stage enable (level)
//   pwm_in        : raw PWM, synchronous to clk
//   dead_time     : gap length in clk cycles, sampled only when a gap starts
//   fault         : fault request (level), fault_clr: one-cycle clear pulse
//   pwm_hi/pwm_lo : high/low-side drives, never both 1
//   dt_active     : in a gap state, fault_latched: sticky fault flag
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            dt_active,
    output logic            fault_latched
);

    state_t r_state;
    state_t w_nxt;
    logic   w_zero;
    logic   w_dt_zero;
    logic   w_load;
    logic   w_dec;
    logic   r_pwm_hi;
    logic   r_pwm_lo;
    logic   r_dt_active;
    logic   r_fault_latched;

    assign w_dt_zero = (dead_time == '0);

    always_comb begin
        w_nxt = r_state;
        if (fault) begin
            w_nxt = FAULT;
        end else if (r_state == FAULT) begin
            if (fault_clr) w_nxt = IDLE;
        end else if (!en) begin
            w_nxt = IDLE;
        end else begin
            case (r_state)
                // Leaving IDLE always goes through a gap, even with dead_time 0
                IDLE:    w_nxt = pwm_in ? DT_RISE : DT_FALL;
                // A reversal inside a gap restarts the opposite gap, swallowing short pulses
                DT_RISE: begin
                    if (!pwm_in)     w_nxt = DT_FALL;
                    else if (w_zero) w_nxt = HI_ON;
                end
                HI_ON:   if (!pwm_in) w_nxt = w_dt_zero ? LO_ON : DT_FALL;
                DT_FALL: begin
                    if (pwm_in)      w_nxt = DT_RISE;
                    else if (w_zero) w_nxt = LO_ON;
                end
                LO_ON:   if (pwm_in) w_nxt = w_dt_zero ? HI_ON : DT_RISE;
                default: w_nxt = IDLE;
            endcase
        end
    end

    // Load on every entry into a gap state (including a gap-to-gap reversal),
    // count down while the same gap state persists.
    assign w_load = is_dt(w_nxt) && (w_nxt != r_state);
    assign w_dec  = is_dt(w_nxt) && (w_nxt == r_state);

    dt_counter #(
        .W (DT_W)
    ) u_dt_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_len  (dead_time),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    // Outputs are registered alongside the state so they always equal the
    // decode of the registered state and carry no combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_pwm_hi        <= 1'b0;
            r_pwm_lo        <= 1'b0;
            r_dt_active     <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_state         <= w_nxt;
            r_pwm_hi        <= (w_nxt == HI_ON);
            r_pwm_lo        <= (w_nxt == LO_ON);
            r_dt_active     <= is_dt(w_nxt);
            r_fault_latched <= (w_nxt == FAULT);
        end
    end

    assign pwm_hi        = r_pwm_hi;
    assign pwm_lo        = r_pwm_lo;
    assign dt_active     = r_dt_active;
    assign fault_latched = r_fault_latched;

endmodule
